// File: rtl/neureka_weight_plane_feeder_pkg.sv
`default_nettype none
// ============================================================================
// neureka_package : shared sizes and types for the NEUREKA weight plane feeder
// Revision: 1.0
// ============================================================================
package neureka_package;

    localparam int NEUREKA_COLUMN_SIZE = 9;
    localparam int NEUREKA_BLOCK_SIZE  = 32;
    localparam int NEUREKA_QW_MAX      = 8;
    localparam int NEUREKA_QW_W        = $clog2(NEUREKA_QW_MAX);

    typedef struct packed {
        logic                    idle;
        logic [NEUREKA_QW_W-1:0] plane_idx;
        logic                    last_plane;
    } weight_feeder_flags_t;

    typedef enum logic [0:0] {
        FEED_EMPTY = 1'b0,
        FEED_FULL  = 1'b1
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/neureka_weight_feeder_skid.sv
`default_nettype none
// ============================================================================
// neureka_weight_feeder_skid : one-entry word+qw buffer with a registered ready
// Revision: 1.0
// ============================================================================
module neureka_weight_feeder_skid #(
    parameter int WORD_W = 2304,
    parameter int QW_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic [QW_W-1:0]   in_qw_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic [QW_W-1:0]   out_qw_o,
    input  logic              out_ready_i
);

    logic              full_d, full_q;
    logic [WORD_W-1:0] data_d, data_q;
    logic [QW_W-1:0]   qw_d,   qw_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        qw_d   = qw_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (!full_q && in_valid_i) begin
            full_d = 1'b1;
            data_d = in_data_i;
            qw_d   = in_qw_i;
        end else if (full_q && out_ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
            qw_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            qw_q   <= qw_d;
        end
    end

    assign in_ready_o  = ~full_q;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;
    assign out_qw_o    = qw_q;

endmodule
`default_nettype wire

// File: rtl/neureka_weight_plane_feeder.sv
`default_nettype none
// ============================================================================
// neureka_weight_plane_feeder : replays a packed multi-plane weight word one
// bit-plane per handshake, LSB plane first, as COLUMN_SIZE parallel streams.
// Option: NEUREKA_WEIGHT_FEEDER_SKID_EN adds a registered-ready input buffer.
// Revision: 1.0
// ============================================================================
module neureka_weight_plane_feeder
    import neureka_package::*;
#(
    parameter int COLUMN_SIZE = NEUREKA_COLUMN_SIZE,
    parameter int BLOCK_SIZE  = NEUREKA_BLOCK_SIZE,
    parameter int QW_MAX      = NEUREKA_QW_MAX
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  enable_i,
    input  logic [$clog2(QW_MAX)-1:0]             qw_m1_i,
    input  logic                                  weight_i_valid,
    input  logic [QW_MAX*COLUMN_SIZE*BLOCK_SIZE-1:0] weight_i_data,
    output logic                                  weight_i_ready,
    output logic                                  weight_o_valid,
    output logic [COLUMN_SIZE-1:0][BLOCK_SIZE-1:0] weight_o_data,
    output logic [COLUMN_SIZE-1:0][BLOCK_SIZE/8-1:0] weight_o_strb,
    input  logic [COLUMN_SIZE-1:0]                weight_o_ready,
    output logic [$clog2(QW_MAX)-1:0]             plane_idx_o,
    output logic                                  last_plane_o,
    output logic                                  idle_o
);

    localparam int WORD_W = QW_MAX*COLUMN_SIZE*BLOCK_SIZE;
    localparam int QW_W   = $clog2(QW_MAX);

    feeder_state_e      state_d, state_q;
    logic [WORD_W-1:0]  word_d,  word_q;
    logic [QW_W-1:0]    qw_d,    qw_q;
    logic [QW_W-1:0]    cnt_d,   cnt_q;

    logic               full;
    logic               out_ready;
    logic               out_hs;
    logic               last_plane;
    logic               load_ready;
    logic               load;
    logic               src_valid;
    logic [WORD_W-1:0]  src_data;
    logic [QW_W-1:0]    src_qw;
    logic               buf_empty;
    weight_feeder_flags_t flags;

    // The consumer ties all ready bits together; only bit 0 is looked at.
    logic unused_ready;
    assign unused_ready = ^weight_o_ready[COLUMN_SIZE-1:1];

    assign full       = (state_q == FEED_FULL);
    assign out_ready  = weight_o_ready[0];
    assign out_hs     = full & out_ready & enable_i;
    assign last_plane = (cnt_q == qw_q);
    assign load_ready = ~full | (last_plane & out_hs);
    assign load       = src_valid & load_ready;

`ifdef NEUREKA_WEIGHT_FEEDER_SKID_EN
    logic skid_valid;
    assign src_valid = skid_valid;
    assign buf_empty = ~skid_valid;

    neureka_weight_feeder_skid #(
        .WORD_W (WORD_W),
        .QW_W   (QW_W)
    ) i_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (weight_i_valid),
        .in_data_i   (weight_i_data),
        .in_qw_i     (qw_m1_i),
        .in_ready_o  (weight_i_ready),
        .out_valid_o (skid_valid),
        .out_data_o  (src_data),
        .out_qw_o    (src_qw),
        .out_ready_i (load_ready)
    );
`else
    assign src_valid      = weight_i_valid;
    assign src_data       = weight_i_data;
    assign src_qw         = qw_m1_i;
    assign buf_empty      = 1'b1;
    assign weight_i_ready = load_ready;
`endif

    // Clear wins over both a new load and a plane advance.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        qw_d    = qw_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = FEED_EMPTY;
            cnt_d   = '0;
        end else if (load) begin
            state_d = FEED_FULL;
            word_d  = src_data;
            qw_d    = src_qw;
            cnt_d   = '0;
        end else if (out_hs) begin
            if (last_plane) begin
                state_d = FEED_EMPTY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + QW_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FEED_EMPTY;
            word_q  <= '0;
            qw_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            qw_q    <= qw_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar j;
    generate
        for (j = 0; j < COLUMN_SIZE; j++) begin : g_stream
            assign weight_o_data[j] = full ?
                word_q[(int'(cnt_q)*COLUMN_SIZE + j)*BLOCK_SIZE +: BLOCK_SIZE] : '0;
            assign weight_o_strb[j] = '1;
        end
    endgenerate

    assign flags.idle       = ~full & buf_empty;
    assign flags.plane_idx  = cnt_q;
    assign flags.last_plane = full & last_plane;

    assign weight_o_valid = full;
    assign plane_idx_o    = flags.plane_idx;
    assign last_plane_o   = flags.last_plane;
    assign idle_o         = flags.idle;

endmodule
`default_nettype wire

// File: tb/tb_neureka_weight_plane_feeder.sv
`default_nettype none
// ============================================================================
// tb_neureka_weight_plane_feeder : directed self-checking bench for the feeder
// Revision: 1.0
// ============================================================================
module tb_neureka_weight_plane_feeder;

    localparam int C_COL  = 9;
    localparam int C_BLK  = 32;
    localparam int C_QW   = 8;
    localparam int C_WORD = C_QW*C_COL*C_BLK;

    logic                          clk = 1'b0;
    logic                          rst_ni;
    logic                          clear_i;
    logic                          enable_i;
    logic [2:0]                    qw_m1_i;
    logic                          weight_i_valid;
    logic [C_WORD-1:0]             weight_i_data;
    logic                          weight_i_ready;
    logic                          weight_o_valid;
    logic [C_COL-1:0][C_BLK-1:0]   weight_o_data;
    logic [C_COL-1:0][C_BLK/8-1:0] weight_o_strb;
    logic [C_COL-1:0]              weight_o_ready;
    logic [2:0]                    plane_idx_o;
    logic                          last_plane_o;
    logic                          idle_o;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    neureka_weight_plane_feeder dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .enable_i       (enable_i),
        .qw_m1_i        (qw_m1_i),
        .weight_i_valid (weight_i_valid),
        .weight_i_data  (weight_i_data),
        .weight_i_ready (weight_i_ready),
        .weight_o_valid (weight_o_valid),
        .weight_o_data  (weight_o_data),
        .weight_o_strb  (weight_o_strb),
        .weight_o_ready (weight_o_ready),
        .plane_idx_o    (plane_idx_o),
        .last_plane_o   (last_plane_o),
        .idle_o         (idle_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane pattern: tag byte, zero byte, plane byte, stream byte.
    function automatic logic [31:0] pat(input logic [7:0] tag, input int p, input int j);
        return {tag, 8'h00, 8'(p), 8'(j)};
    endfunction

    function automatic logic [C_WORD-1:0] mk_word(input logic [7:0] tag);
        logic [C_WORD-1:0] w;
        w = '0;
        for (int p = 0; p < C_QW; p++)
            for (int j = 0; j < C_COL; j++)
                w[(p*C_COL+j)*C_BLK +: C_BLK] = pat(tag, p, j);
        return w;
    endfunction

    task automatic send(input logic [7:0] tag, input int qw);
        @(negedge clk);
        weight_i_data  = mk_word(tag);
        qw_m1_i        = 3'(qw);
        weight_i_valid = 1'b1;
        check_val("send_ready", 32'(weight_i_ready), 32'd1);
    endtask

    task automatic drain(input logic [7:0] tag, input int n, input int stall_lo,
                         input int stall_hi, input bit by_en, input int new_qw);
        int  exp_p;
        int  hs;
        bit  stall;
        exp_p = 0;
        hs    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            weight_i_valid = 1'b0;
            if (cyc == 2 && new_qw >= 0) qw_m1_i = 3'(new_qw);
            if (hs == n) begin
                check_val("end_valid", 32'(weight_o_valid), 32'd0);
                check_val("end_idle",  32'(idle_o),         32'd1);
                check_val("end_idx",   32'(plane_idx_o),    32'd0);
                break;
            end
            check_val("valid", 32'(weight_o_valid), 32'd1);
            check_val("idx",   32'(plane_idx_o),    32'(exp_p));
            check_val("last",  32'(last_plane_o),   32'(exp_p == n-1));
            check_val("data2", weight_o_data[2],    pat(tag, exp_p, 2));
            check_val("data8", weight_o_data[8],    pat(tag, exp_p, 8));
            stall = (cyc >= stall_lo) && (cyc <= stall_hi);
            if (by_en) begin
                enable_i       = ~stall;
                weight_o_ready = '1;
            end else begin
                enable_i       = 1'b1;
                weight_o_ready = stall ? '0 : '1;
            end
            if (!stall) begin
                exp_p++;
                hs++;
            end
        end
        enable_i       = 1'b1;
        weight_o_ready = '1;
        check_val("hs_count", 32'(hs), 32'(n));
    endtask

    initial begin
        rst_ni         = 1'b1;
        clear_i        = 1'b0;
        enable_i       = 1'b1;
        qw_m1_i        = '0;
        weight_i_valid = 1'b0;
        weight_i_data  = '0;
        weight_o_ready = '1;
        #1 rst_ni = 1'b0;
        #1;
        check_val("rst_valid", 32'(weight_o_valid), 32'd0);
        check_val("rst_data",  weight_o_data[0],    32'd0);
        check_val("rst_idx",   32'(plane_idx_o),    32'd0);
        check_val("rst_last",  32'(last_plane_o),   32'd0);
        check_val("rst_idle",  32'(idle_o),         32'd1);
        check_val("rst_ready", 32'(weight_i_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // Single word, four planes, no stalls.
        send(8'hA1, 3);
        drain(8'hA1, 4, -1, -1, 1'b0, -1);

        // Ready backpressure on cycles 2-4 of an eight-plane word.
        send(8'hB2, 7);
        drain(8'hB2, 8, 2, 4, 1'b0, -1);

        // enable_i low for two cycles stalls the replay.
        send(8'hC3, 3);
        drain(8'hC3, 4, 1, 2, 1'b1, -1);

        // Back-to-back: A (2 planes) then B (1 plane), valid held high.
        @(negedge clk);
        weight_i_data  = mk_word(8'hD4);
        qw_m1_i        = 3'd1;
        weight_i_valid = 1'b1;
        check_val("b2b_ready0", 32'(weight_i_ready), 32'd1);
        @(negedge clk);
        weight_i_data  = mk_word(8'hE5);
        qw_m1_i        = 3'd0;
        check_val("b2b_a0",     weight_o_data[2],    pat(8'hD4, 0, 2));
        check_val("b2b_a0_rdy", 32'(weight_i_ready), 32'd0);
        @(negedge clk);
        check_val("b2b_a1",     weight_o_data[2],    pat(8'hD4, 1, 2));
        check_val("b2b_a1_idx", 32'(plane_idx_o),    32'd1);
        check_val("b2b_a1_rdy", 32'(weight_i_ready), 32'd1);
        @(negedge clk);
        weight_i_valid = 1'b0;
        check_val("b2b_b0_vld", 32'(weight_o_valid), 32'd1);
        check_val("b2b_b0",     weight_o_data[2],    pat(8'hE5, 0, 2));
        check_val("b2b_b0_idx", 32'(plane_idx_o),    32'd0);
        check_val("b2b_b0_lst", 32'(last_plane_o),   32'd1);
        @(negedge clk);
        check_val("b2b_idle",   32'(idle_o),         32'd1);

        // qw_m1_i changed mid-replay only affects the next word.
        send(8'h16, 7);
        drain(8'h16, 8, -1, -1, 1'b0, 2);
        send(8'h27, 2);
        drain(8'h27, 3, -1, -1, 1'b0, -1);

        // clear_i together with the handshake of plane 2.
        send(8'h38, 7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            weight_i_valid = 1'b0;
            check_val("clr_idx", 32'(plane_idx_o), 32'(k));
            if (k == 2) clear_i = 1'b1;
        end
        @(negedge clk);
        clear_i = 1'b0;
        check_val("clr_valid", 32'(weight_o_valid), 32'd0);
        check_val("clr_idle",  32'(idle_o),         32'd1);
        check_val("clr_idx0",  32'(plane_idx_o),    32'd0);
        check_val("clr_ready", 32'(weight_i_ready), 32'd1);

        // Asynchronous reset mid-word.
        send(8'h49, 7);
        @(negedge clk);
        weight_i_valid = 1'b0;
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check_val("arst_valid", 32'(weight_o_valid), 32'd0);
        check_val("arst_data",  weight_o_data[2],    32'd0);
        check_val("arst_idx",   32'(plane_idx_o),    32'd0);
        check_val("arst_last",  32'(last_plane_o),   32'd0);
        check_val("arst_idle",  32'(idle_o),         32'd1);
        check_val("arst_ready", 32'(weight_i_ready), 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        send(8'h5A, 1);
        drain(8'h5A, 2, -1, -1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
